// File: rtl/pic_irq_resolver_pkg.sv
// rtl/pic_irq_resolver_pkg.sv - shared types, constants and rank helper for the interrupt resolver
package pic_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ACK1 = 2'd1;
  localparam state_t ACK2 = 2'd2;

  localparam logic [2:0] SPURIOUS_CODE = 3'd7;

  // Rank 0 is the highest priority; the IR just above rot_base gets rank 0.
  function automatic logic [2:0] rank(input logic [2:0] i, input logic [2:0] rot_base);
    return i - rot_base - 3'd1;
  endfunction

endpackage

// File: rtl/pic_irq_resolver_prio_enc.sv
// rtl/pic_irq_resolver_prio_enc.sv - rotating priority encoder over eight request lines
module pic_prio_enc
  import pic_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [2:0] rot_base,
  output logic       valid,
  output logic [2:0] index,
  output logic [2:0] rank
);

  // Keep the set bit with the smallest rank under the current rotation.
  always_comb begin
    valid = 1'b0;
    index = 3'd0;
    rank  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i] && (!valid || (pic_pkg::rank(3'(i), rot_base) < rank))) begin
        valid = 1'b1;
        index = 3'(i);
        rank  = pic_pkg::rank(3'(i), rot_base);
      end
    end
  end

endmodule

// File: rtl/pic_irq_resolver.sv
// rtl/pic_irq_resolver.sv - request, mask, in-service and priority stage of the interrupt controller
module pic_irq_resolver
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       ltim,
  input  logic       inta,
  input  logic       aeoi,
  input  logic       wr_imr,
  input  logic       clr_imr,
  input  logic [7:0] imr_data,
  input  logic [7:0] eoi_clr,
  input  logic [2:0] rot_base,
  input  logic       rd_irr,
  input  logic       rd_isr,
  input  logic       rd_imr,
  output logic       int_req,
  output logic [2:0] code,
  output logic [7:0] rd_data
);

  logic [7:0] ir_q, irr, isr, imr;
  logic       inta_q;
  logic       inta_armed;
  state_t     state;

  logic [7:0] cand, ack_mask, aeoi_mask, irr_n, isr_n;
  logic       inta_fall, inta_rise, ack_first, ack_valid;
  logic       win_valid, isr_valid;
  logic [2:0] win, win_rank, isr_rank, isr_top_unused;

  assign cand = irr & ~imr;

  pic_prio_enc u_cand_enc (
    .vec      (cand),
    .rot_base (rot_base),
    .valid    (win_valid),
    .index    (win),
    .rank     (win_rank)
  );

  pic_prio_enc u_isr_enc (
    .vec      (isr),
    .rot_base (rot_base),
    .valid    (isr_valid),
    .index    (isr_top_unused),
    .rank     (isr_rank)
  );

  // Edge detection, nesting decision and next-state values for IRR/ISR.
  always_comb begin
    inta_fall = inta_armed & inta_q & ~inta;
    inta_rise = ~inta_q & inta;
    int_req   = win_valid && (!isr_valid || (win_rank < isr_rank));
    ack_first = (state == IDLE) && inta_fall;
    ack_valid = ack_first && int_req;
    ack_mask  = ack_valid ? (8'h01 << win) : 8'h00;
    aeoi_mask = ((state == ACK2) && inta_rise && aeoi) ? (8'h01 << code) : 8'h00;
    if (ltim) begin
      irr_n = ir_q & ~ack_mask;
    end else begin
      irr_n = (irr | (~ir_q & ir)) & ir & ~ack_mask;
    end
    isr_n = (isr & ~eoi_clr & ~aeoi_mask) | ack_mask;
  end

  // Register state; inta must be seen high after reset before a fall counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q       <= 8'h00;
      inta_q     <= 1'b1;
      inta_armed <= 1'b0;
      irr        <= 8'h00;
      isr        <= 8'h00;
      imr        <= 8'h00;
      code       <= 3'd0;
      state      <= IDLE;
    end else begin
      ir_q   <= ir;
      inta_q <= inta;
      if (inta) inta_armed <= 1'b1;
      irr <= irr_n;
      isr <= isr_n;
      if (clr_imr)     imr <= 8'h00;
      else if (wr_imr) imr <= imr_data;
      if (ack_first) code <= ack_valid ? win : SPURIOUS_CODE;
      case (state)
        IDLE:    if (inta_fall) state <= ACK1;
        ACK1:    if (inta_fall) state <= ACK2;
        ACK2:    if (inta_rise) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data = rd_imr ? imr : rd_isr ? isr : rd_irr ? irr : 8'h00;

endmodule

// File: tb/tb_pic_irq_resolver.sv
// tb/tb_pic_irq_resolver.sv - directed self-checking bench for the interrupt resolver
module tb_pic_irq_resolver;

  logic       clk = 1'b0;
  logic       reset, ltim, inta, aeoi, wr_imr, clr_imr;
  logic       rd_irr, rd_isr, rd_imr;
  logic [7:0] ir, imr_data, eoi_clr;
  logic [2:0] rot_base;
  logic       int_req;
  logic [2:0] code;
  logic [7:0] rd_data;

  int total  = 0;
  int passes = 0;

  pic_irq_resolver dut (
    .clk      (clk),
    .reset    (reset),
    .ir       (ir),
    .ltim     (ltim),
    .inta     (inta),
    .aeoi     (aeoi),
    .wr_imr   (wr_imr),
    .clr_imr  (clr_imr),
    .imr_data (imr_data),
    .eoi_clr  (eoi_clr),
    .rot_base (rot_base),
    .rd_irr   (rd_irr),
    .rd_isr   (rd_isr),
    .rd_imr   (rd_imr),
    .int_req  (int_req),
    .code     (code),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic rd(input int sel, output logic [7:0] val);
    rd_irr = (sel == 0);
    rd_isr = (sel == 1);
    rd_imr = (sel == 2);
    #1;
    val = rd_data;
    rd_irr = 1'b0;
    rd_isr = 1'b0;
    rd_imr = 1'b0;
    #1;
  endtask

  task automatic inta_cycle();
    inta = 1'b0; tick();
    inta = 1'b1; tick();
    inta = 1'b0; tick();
    inta = 1'b1; tick();
  endtask

  logic [7:0] v;

  initial begin
    reset = 1'b1; ir = 8'h00; ltim = 1'b0; inta = 1'b1; aeoi = 1'b0;
    wr_imr = 1'b0; clr_imr = 1'b0; imr_data = 8'h00; eoi_clr = 8'h00;
    rot_base = 3'd7; rd_irr = 1'b0; rd_isr = 1'b0; rd_imr = 1'b0;
    tick(); tick();
    chk("rst_int_req", {7'd0, int_req}, 8'h00);
    chk("rst_code", {5'd0, code}, 8'h00);
    chk("rst_rd_none", rd_data, 8'h00);
    rd(0, v); chk("rst_irr", v, 8'h00);
    rd(1, v); chk("rst_isr", v, 8'h00);
    rd(2, v); chk("rst_imr", v, 8'h00);
    reset = 1'b0; tick();

    // fixed priority
    ir = 8'h24; tick(); tick();
    chk("fix_int_req", {7'd0, int_req}, 8'h01);
    rd(0, v); chk("fix_irr", v, 8'h24);
    inta_cycle();
    chk("fix_code", {5'd0, code}, 8'h02);
    rd(1, v); chk("fix_isr", v, 8'h04);
    rd(0, v); chk("fix_irr_after", v, 8'h20);
    chk("fix_int_low", {7'd0, int_req}, 8'h00);

    // EOI and nesting
    eoi_clr = 8'h04; tick(); eoi_clr = 8'h00;
    rd(1, v); chk("eoi_isr", v, 8'h00);
    chk("eoi_int_req", {7'd0, int_req}, 8'h01);
    inta_cycle();
    chk("nest_code5", {5'd0, code}, 8'h05);
    rd(1, v); chk("nest_isr5", v, 8'h20);
    chk("nest_int_low", {7'd0, int_req}, 8'h00);
    ir = 8'h26; tick(); tick();
    chk("nest_preempt", {7'd0, int_req}, 8'h01);
    rd(0, v); chk("nest_irr", v, 8'h02);
    inta_cycle();
    chk("nest_code1", {5'd0, code}, 8'h01);
    rd(1, v); chk("nest_isr_both", v, 8'h22);
    eoi_clr = 8'h22; tick(); eoi_clr = 8'h00;
    ir = 8'h00; tick();

    // mask
    ir = 8'h20; tick(); tick();
    chk("mask_pre", {7'd0, int_req}, 8'h01);
    wr_imr = 1'b1; imr_data = 8'h20; tick(); wr_imr = 1'b0;
    chk("mask_int_low", {7'd0, int_req}, 8'h00);
    rd(2, v); chk("mask_rd_imr", v, 8'h20);
    clr_imr = 1'b1; tick(); clr_imr = 1'b0;
    chk("mask_clr_int", {7'd0, int_req}, 8'h01);
    rd(2, v); chk("mask_imr_clr", v, 8'h00);
    inta_cycle();
    eoi_clr = 8'h20; tick(); eoi_clr = 8'h00;
    ir = 8'h00; tick();

    // rotation: IR4 rank 0, IR7 rank 3, IR0 rank 4, IR1 rank 5
    rot_base = 3'd3;
    ir = 8'h11; tick(); tick();
    inta_cycle();
    chk("rot_code4", {5'd0, code}, 8'h04);
    rd(0, v); chk("rot_irr", v, 8'h01);
    eoi_clr = 8'h10; tick(); eoi_clr = 8'h00;
    chk("rot_ir0_req", {7'd0, int_req}, 8'h01);
    inta_cycle();
    chk("rot_code0", {5'd0, code}, 8'h00);
    ir = 8'h13; tick(); tick();
    chk("rot_ir1_below", {7'd0, int_req}, 8'h00);
    ir = 8'h93; tick(); tick();
    chk("rot_ir7_above", {7'd0, int_req}, 8'h01);
    ir = 8'h00; tick();
    eoi_clr = 8'h01; tick(); eoi_clr = 8'h00;
    rot_base = 3'd7;

    // spurious
    ir = 8'h08; tick();
    ir = 8'h00; tick();
    inta_cycle();
    chk("spur_code", {5'd0, code}, 8'h07);
    rd(1, v); chk("spur_isr", v, 8'h00);

    // automatic EOI
    aeoi = 1'b1;
    ir = 8'h04; tick(); tick();
    inta = 1'b0; tick();
    rd(1, v); chk("aeoi_isr_set", v, 8'h04);
    inta = 1'b1; tick();
    inta = 1'b0; tick();
    rd(1, v); chk("aeoi_isr_ack2", v, 8'h04);
    inta = 1'b1; tick();
    rd(1, v); chk("aeoi_isr_clr", v, 8'h00);
    chk("aeoi_code", {5'd0, code}, 8'h02);
    aeoi = 1'b0;
    ir = 8'h00; tick();

    // reset mid-acknowledge with inta held low
    ir = 8'h40; tick(); tick();
    inta = 1'b0; tick();
    chk("rstack_code6", {5'd0, code}, 8'h06);
    reset = 1'b1; ir = 8'h00; tick();
    chk("rstack_int", {7'd0, int_req}, 8'h00);
    chk("rstack_code", {5'd0, code}, 8'h00);
    rd(1, v); chk("rstack_isr", v, 8'h00);
    reset = 1'b0;
    ir = 8'h20; tick(); tick(); tick();
    rd(1, v); chk("held_low_no_ack", v, 8'h00);
    chk("held_low_int", {7'd0, int_req}, 8'h01);
    inta = 1'b1; tick();
    inta = 1'b0; tick();
    chk("rearm_code", {5'd0, code}, 8'h05);
    rd(1, v); chk("rearm_isr", v, 8'h20);
    inta = 1'b1; tick();
    inta = 1'b0; tick();
    inta = 1'b1; tick();
    eoi_clr = 8'h20; tick(); eoi_clr = 8'h00;
    ir = 8'h00; tick();

    // level mode
    ltim = 1'b1;
    ir = 8'h08; tick(); tick();
    chk("lvl_int_req", {7'd0, int_req}, 8'h01);
    inta_cycle();
    chk("lvl_code", {5'd0, code}, 8'h03);
    chk("lvl_int_low", {7'd0, int_req}, 8'h00);
    rd(0, v); chk("lvl_irr_back", v, 8'h08);
    eoi_clr = 8'h08; tick(); eoi_clr = 8'h00;
    chk("lvl_reassert", {7'd0, int_req}, 8'h01);
    rd(0, v); chk("lvl_irr", v, 8'h08);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
